dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate L1 data cache controller for the MEM stage.
//  Sits between EX/MEM outputs (ALU result as address, forwarded RS2 data) and a slow line-wide data memory.
//  Serves hits in the same cycle. On a miss it stalls the whole pipeline, writes back a dirty victim, then refills the line.
// PARAMETERS
//  INDEX_W   4     index bits; 2**INDEX_W lines
//  LINE_W    256   line width in bits (32 B, 8 words); offset = addr[4:0], word select = addr[4:2]
//  TAG_W     32-5-INDEX_W   tag width (derived localparam, not overridable)
// PORTS
//  clk_i        in   1       clock, all state updates on rising edge
//  rst_i        in   1       synchronous, active-high reset
//  cpu_req_i    in   1       MEM stage access valid (MemRead | MemWrite)
//  cpu_we_i     in   1       1 = store word, 0 = load word
//  cpu_addr_i   in   32      byte address; bits [1:0] ignored
//  cpu_wdata_i  in   32      store data
//  cpu_rdata_o  out  32      load data, valid when cpu_req_i & !cpu_we_i & !cpu_stall_o
//  cpu_stall_o  out  1       freeze PC/IFID/IDEX/EXMEM/MEMWB while 1
//  mem_req_o    out  1       memory request, held until acknowledged
//  mem_we_o     out  1       1 = line write-back, 0 = line fetch
//  mem_addr_o   out  32      line-aligned address ([4:0]=0)
//  mem_wdata_o  out  LINE_W  victim line data
//  mem_rdata_i  in   LINE_W  fetched line, valid with mem_ack_i
//  mem_ack_i    in   1       one-cycle completion pulse
//  hit_cnt_o    out  32      only with DCACHE_STATS_EN
//  miss_cnt_o   out  32      only with DCACHE_STATS_EN
// BEHAVIOUR
//  - Reset: state IDLE; all valid/dirty bits 0; mem_req_o=0, mem_we_o=0, mem_addr_o=0, cpu_stall_o=0, cpu_rdata_o=0; counters 0.
//  - Hit = cpu_req_i & valid[idx] & tag[idx]==addr tag.
//  - Hit handling, all in IDLE:
//    - cpu_stall_o=0.
//    - Load: cpu_rdata_o is combinational from the line, 0 latency.
//    - Store: writes the selected word and sets dirty on the same edge.
//  - States: IDLE, WRITEBACK, ALLOCATE, RESUME.
//    - IDLE:
//      - Miss with victim valid & dirty -> WRITEBACK.
//      - Miss otherwise -> ALLOCATE.
//      - cpu_stall_o rises combinationally in the miss cycle.
//    - WRITEBACK:
//      - mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, idx, 5'b0}, mem_wdata_o=victim line.
//      - On mem_ack_i -> ALLOCATE.
//    - ALLOCATE:
//      - mem_req_o=1, mem_we_o=0, mem_addr_o={req tag, idx, 5'b0}.
//      - On mem_ack_i: line<=mem_rdata_i, tag updated, valid=1, dirty=0 -> RESUME.
//    - RESUME:
//      - cpu_stall_o=1 for this one cycle; then IDLE, where the access re-hits.
//      - A store therefore sets dirty on the re-hit.
//  - cpu_stall_o=1 in every state except IDLE.
//  - Handshake:
//    - mem_addr_o, mem_we_o and mem_wdata_o are registered and stable while mem_req_o=1.
//    - mem_req_o drops the cycle after mem_ack_i.
//    - mem_ack_i while mem_req_o=0 is ignored.
//    - Ack in the first request cycle is legal.
//  - Minimum miss penalty: clean miss = 3 stall cycles (ALLOCATE, ack, RESUME); dirty miss adds at least 2.
//  - cpu_req_i dropping while stalled: the refill still completes; the line is installed.
//  - cpu_req_i=0: no state change; cpu_rdata_o don't-care.
//  - Reset mid-miss: FSM returns to IDLE next edge, mem_req_o=0, all lines invalidated; dirty data is lost.
//  - Index wrap: address bits above the tag alias by design. No special handling.
// CONFIGURATION
//  DCACHE_STATS_EN defined:
//    - hit_cnt_o and miss_cnt_o ports exist.
//    - hit_cnt_o +1 per IDLE-cycle hit, excluding the re-hit that follows RESUME.
//    - miss_cnt_o +1 per IDLE->WRITEBACK/ALLOCATE transition.
//    - Both saturate at 32'hFFFF_FFFF.
//  DCACHE_STATS_EN undefined: ports and counter logic are absent; behaviour is otherwise identical.
// TESTING
//  1. Reset, load 0x100 (memory returns 0x...AA at word 0) -> stall 3 cycles; mem_addr_o=0x100, mem_we_o=0; cpu_rdata_o=0x...AA.
//  2. Store 0xDEADBEEF to 0x104 after T1 -> no stall; immediate load 0x104 returns 0xDEADBEEF; no mem_req_o.
//  3. Load 0x300 (same idx, dirty) -> write-back first: mem_we_o=1, mem_addr_o=0x100, word1=0xDEADBEEF; then fetch 0x300.
//  4. Memory acks after 10 cycles -> mem_req_o and mem_addr_o stay stable all 10 cycles; mem_req_o low the cycle after ack.
//  5. rst_i asserted in ALLOCATE -> next cycle mem_req_o=0, cpu_stall_o=0; reload 0x100 misses again.
//  6. With DCACHE_STATS_EN, run T1-T3 -> hit_cnt_o=2, miss_cnt_o=2.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller for the MEM stage.
// Optional hit/miss counters are built only when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int INDEX_W = 4,
  parameter int LINE_W  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int TAG_W = 32 - 5 - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, RESUME} state_t;

  state_t             state;
  logic [LINES-1:0]   valid;
  logic [LINES-1:0]   dirty;
  logic [TAG_W-1:0]   tags  [LINES];
  logic [LINE_W-1:0]  lines [LINES];
  logic [INDEX_W-1:0] idx;
  logic [INDEX_W-1:0] miss_idx;
  logic [TAG_W-1:0]   tag;
  logic [TAG_W-1:0]   miss_tag;
  logic [2:0]         word;
  logic               hit;
  logic               unused_addr;

  assign idx         = cpu_addr_i[5+INDEX_W-1:5];
  assign tag         = cpu_addr_i[31:5+INDEX_W];
  assign word        = cpu_addr_i[4:2];
  assign unused_addr = ^cpu_addr_i[1:0];

  assign hit         = cpu_req_i & valid[idx] & (tags[idx] == tag);
  assign cpu_rdata_o = (state == IDLE && hit) ? lines[idx][{word, 5'b0} +: 32] : 32'h0;
  assign cpu_stall_o = (state != IDLE) | (cpu_req_i & ~hit);

  // The miss tag/index are latched so the refill finishes even if cpu_req_i drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      valid       <= '0;
      dirty       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      miss_idx    <= '0;
      miss_tag    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_i) begin
            if (hit) begin
              if (cpu_we_i) begin
                lines[idx][{word, 5'b0} +: 32] <= cpu_wdata_i;
                dirty[idx]                     <= 1'b1;
              end
            end else begin
              miss_idx  <= idx;
              miss_tag  <= tag;
              mem_req_o <= 1'b1;
              if (valid[idx] && dirty[idx]) begin
                state       <= WRITEBACK;
                mem_we_o    <= 1'b1;
                mem_addr_o  <= {tags[idx], idx, 5'b0};
                mem_wdata_o <= lines[idx];
              end else begin
                state      <= ALLOCATE;
                mem_we_o   <= 1'b0;
                mem_addr_o <= {tag, idx, 5'b0};
              end
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= {miss_tag, miss_idx, 5'b0};
            state      <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          // After a write-back the request is idle for one cycle before the fetch is raised.
          if (mem_req_o && mem_ack_i) begin
            mem_req_o       <= 1'b0;
            lines[miss_idx] <= mem_rdata_i;
            tags[miss_idx]  <= miss_tag;
            valid[miss_idx] <= 1'b1;
            dirty[miss_idx] <= 1'b0;
            state           <= RESUME;
          end else if (!mem_req_o) begin
            mem_req_o <= 1'b1;
          end
        end
        RESUME:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic rehit;

  // The first IDLE cycle after RESUME is the replay of a counted miss, not a new hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rehit      <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      rehit <= (state == RESUME);
      if (state == IDLE && hit && !rehit && hit_cnt_o != 32'hFFFF_FFFF)
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if (state == IDLE && cpu_req_i && !hit && miss_cnt_o != 32'hFFFF_FFFF)
        miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: vector table of CPU accesses, line-memory responder
// with configurable ack delay, handshake monitor, and hand-written reset/drop sequences.
module tb_dcache_ctrl;

  localparam int LINE_W = 256;
  localparam int NV     = 12;

  logic              clk;
  logic              rst;
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int ack_delay = 0;

  logic [31:0]       exp_q [$];
  logic [32:0]       req_log [$];
  logic [LINE_W-1:0] mem_model [logic [31:0]];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stalls;
    int          nwb;
    logic [31:0] wb_addr;
  } vec_t;

  vec_t vecs [NV];

  dcache_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .cpu_stall_o (cpu_stall),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a, input logic [2:0] k);
    return {a[19:0], 1'b0, k, 8'hAA};
  endfunction

  function automatic logic [LINE_W-1:0] model_line(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    if (mem_model.exists(a)) return mem_model[a];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = pat(a, 3'(k));
    return l;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Line memory: acks after ack_delay request cycles, logs each completed transfer.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          req_log.push_back({mem_we, mem_addr});
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = model_line(mem_addr);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Handshake monitor: request fields stable while waiting, request drops after ack.
  initial begin
    logic              p_req, p_ack, p_we, p_rst;
    logic [31:0]       p_addr;
    logic [LINE_W-1:0] p_wdata;
    p_req = 0; p_ack = 0; p_we = 0; p_rst = 1; p_addr = 0; p_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && !p_rst && p_req) begin
        if (p_ack) begin
          check_output("req_drop_after_ack", 64'(mem_req), 64'd0);
        end else if (mem_req) begin
          check_output("req_addr_stable", 64'(mem_addr), 64'(p_addr));
          check_output("req_we_stable", 64'(mem_we), 64'(p_we));
          check_output("req_wdata_stable", 64'(mem_wdata == p_wdata), 64'd1);
        end
      end
      p_req = mem_req; p_ack = mem_ack; p_we = mem_we; p_rst = rst;
      p_addr = mem_addr; p_wdata = mem_wdata;
    end
  end

  // Called #1 after a rising edge; returns there one cycle after the access completes.
  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, output int stalls);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    if (!we) exp_q.push_back(exp_rdata);
    stalls = 0;
    @(negedge clk);
    while (cpu_stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL stall_timeout addr=%h", addr);
    end
    if (!we) check_output($sformatf("rdata@%h", addr), 64'(cpu_rdata), 64'(exp_q.pop_front()));
    @(posedge clk); #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic check_log(input string name, input int nwb, input logic [31:0] wb_addr,
                           input int nfetch, input logic [31:0] fetch_addr);
    check_output({name, "_nreq"}, 64'(req_log.size()), 64'(nwb + nfetch));
    if (req_log.size() == nwb + nfetch) begin
      if (nwb > 0) check_output({name, "_wb"}, 64'(req_log[0]), 64'({1'b1, wb_addr}));
      if (nfetch > 0) check_output({name, "_fetch"}, 64'(req_log[nwb]), 64'({1'b0, fetch_addr}));
    end
    req_log.delete();
  endtask

  initial begin
    int st;
    int n;
    int exp_hits;
    int exp_miss;

    vecs[0]  = '{1'b0, 32'h100, 32'h0,         pat(32'h100, 3'd0), 3, 0, 32'h0};
    vecs[1]  = '{1'b1, 32'h104, 32'hDEADBEEF,  32'h0,              0, 0, 32'h0};
    vecs[2]  = '{1'b0, 32'h104, 32'h0,         32'hDEADBEEF,       0, 0, 32'h0};
    vecs[3]  = '{1'b0, 32'h108, 32'h0,         pat(32'h100, 3'd2), 0, 0, 32'h0};
    vecs[4]  = '{1'b0, 32'h300, 32'h0,         pat(32'h300, 3'd0), 5, 1, 32'h100};
    vecs[5]  = '{1'b0, 32'h104, 32'h0,         32'hDEADBEEF,       3, 0, 32'h0};
    vecs[6]  = '{1'b1, 32'h20C, 32'h12345678,  32'h0,              3, 0, 32'h0};
    vecs[7]  = '{1'b0, 32'h20C, 32'h0,         32'h12345678,       0, 0, 32'h0};
    vecs[8]  = '{1'b0, 32'h21C, 32'h0,         pat(32'h200, 3'd7), 0, 0, 32'h0};
    vecs[9]  = '{1'b0, 32'h40C, 32'h0,         pat(32'h400, 3'd3), 5, 1, 32'h200};
    vecs[10] = '{1'b0, 32'h20C, 32'h0,         32'h12345678,       3, 0, 32'h0};
    vecs[11] = '{1'b0, 32'h1E0, 32'h0,         pat(32'h1E0, 3'd0), 3, 0, 32'h0};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("rst_stall", 64'(cpu_stall), 64'd0);
    check_output("rst_mem_req", 64'(mem_req), 64'd0);
    check_output("rst_mem_we", 64'(mem_we), 64'd0);
    check_output("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_output("rst_rdata", 64'(cpu_rdata), 64'd0);
`ifdef DCACHE_STATS_EN
    check_output("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    check_output("rst_miss_cnt", 64'(miss_cnt), 64'd0);
`endif
    @(posedge clk); #1;
    req_log.delete();

    exp_hits = 0;
    exp_miss = 0;
    for (int i = 0; i < NV; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, st);
      check_output($sformatf("v%0d_stalls", i), 64'(st), 64'(vecs[i].stalls));
      check_log($sformatf("v%0d", i), vecs[i].nwb, vecs[i].wb_addr,
                (vecs[i].stalls > 0) ? 1 : 0, {vecs[i].addr[31:5], 5'b0});
      if (vecs[i].stalls > 0) exp_miss++;
      else                    exp_hits++;
    end
`ifdef DCACHE_STATS_EN
    check_output("hit_cnt", 64'(hit_cnt), 64'(exp_hits));
    check_output("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
`endif

    // Slow memory: fetch held for 11 request cycles.
    ack_delay = 10;
    apply_stimulus(1'b0, 32'h500, 32'h0, pat(32'h500, 3'd0), st);
    check_output("slow_stalls", 64'(st), 64'd13);
    check_log("slow", 0, 32'h0, 1, 32'h500);
    ack_delay = 0;

    // Request withdrawn during the miss: refill must still install the line.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h700;
    @(negedge clk);
    check_output("drop_miss_stall", 64'(cpu_stall), 64'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (cpu_stall && n < 50) begin
      n++;
      @(negedge clk);
    end
    check_output("drop_refill_done", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    check_log("drop", 0, 32'h0, 1, 32'h700);
    apply_stimulus(1'b0, 32'h700, 32'h0, pat(32'h700, 3'd0), st);
    check_output("drop_rehit_stalls", 64'(st), 64'd0);

    // Reset while ALLOCATE is waiting on a slow ack.
    ack_delay = 20;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h600;
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 10) begin
      n++;
      @(negedge clk);
    end
    check_output("rstmid_req_seen", 64'(mem_req), 64'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    check_output("rstmid_mem_req", 64'(mem_req), 64'd0);
    check_output("rstmid_stall", 64'(cpu_stall), 64'd0);
    rst = 1'b0;
    ack_delay = 0;
    req_log.delete();
    @(posedge clk); #1;
    apply_stimulus(1'b0, 32'h104, 32'h0, 32'hDEADBEEF, st);
    check_output("rstmid_reload_stalls", 64'(st), 64'd3);
    check_log("rstmid", 0, 32'h0, 1, 32'h100);
    apply_stimulus(1'b0, 32'h20C, 32'h0, 32'h12345678, st);
    check_output("rstmid_idx0_stalls", 64'(st), 64'd3);
    check_log("rstmid_idx0", 0, 32'h0, 1, 32'h200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
